// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared opcode constants, format enum, skid FSM states and the
// registered result entry used by imm_gen_pipe / imm_decode.
package imm_gen_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Entry fields are sized for the widest legal configuration; the top level
  // uses the low XLEN / TAG_W bits.
  localparam int IMM_MAX = 64;
  localparam int TAG_MAX = 32;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_SH   = 3'd5,
    FMT_Z    = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_e;

  typedef struct packed {
    logic [IMM_MAX-1:0] imm;
    fmt_e               fmt;
    logic               illegal;
    logic [TAG_MAX-1:0] tag;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

  // funct3 values selecting SLLI / SRLI / SRAI (and the W variants)
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational RV32I/RV64I immediate decoder.
//   instr   : 32-bit instruction word
//   imm     : immediate extended to XLEN
//   fmt     : format code
//   illegal : opcode has no defined format
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0] op;
  logic [2:0] f3;

  assign op = instr[6:0];
  assign f3 = instr[14:12];

  // XLEN'(signed) sign-extends; XLEN'(unsigned) zero-extends.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (op)
      OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(instr[31:20]));
      end
      OP_IMM: begin
        if (is_shift_f3(f3)) begin
          fmt = FMT_SH;
          imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(instr[31:20]));
        end
      end
      OP_IMM32: begin
        // W shifts are 32-bit ops: shamt is always 5 bits
        if (is_shift_f3(f3)) begin
          fmt = FMT_SH;
          imm = XLEN'(instr[24:20]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(instr[31:20]));
        end
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OP_SYSTEM: begin
        // ECALL/EBREAK/xRET have no immediate but are legal
        if (f3 != 3'b000) begin
          fmt = FMT_Z;
          imm = XLEN'(instr[19:15]);
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry skid buffer.
//   clk, rst_n        : clock, async active-low reset
//   flush             : sync flush, empties the buffer
//   in_valid/in_ready : input handshake (in_ready registered)
//   in_instr, in_tag  : instruction and sideband tag
//   out_valid/out_ready, out_imm, out_fmt, out_illegal, out_tag : result
//   illegal_cnt       : saturating count of drained illegal results
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  skid_e           state_q, state_d;
  entry_t          main_q, skid_q, in_entry;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic            accept, drain;
  logic            load_main, load_skid, move_skid;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  always_comb begin
    in_entry         = ENTRY_RST;
    in_entry.imm     = IMM_MAX'(dec_imm);
    in_entry.fmt     = dec_fmt;
    in_entry.illegal = dec_illegal;
    in_entry.tag     = TAG_MAX'(in_tag);
  end

  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      S_EMPTY: if (accept) begin
        state_d   = S_ONE;
        load_main = 1'b1;
      end
      S_ONE: case ({accept, drain})
        2'b10: begin state_d = S_TWO; load_skid = 1'b1; end
        2'b01: state_d = S_EMPTY;
        2'b11: load_main = 1'b1;
        default: ;
      endcase
      S_TWO: if (drain) begin
        state_d   = S_ONE;
        move_skid = 1'b1;
      end
      default: state_d = S_EMPTY;
    endcase
    // flush drops both entries and any same-cycle accept
    if (flush) begin
      state_d   = S_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready    <= 1'b1;
      main_q      <= ENTRY_RST;
      skid_q      <= ENTRY_RST;
      illegal_cnt <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != S_TWO);
      if (load_main)      main_q <= in_entry;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_entry;
      // counts independently of flush
      if (drain && main_q.illegal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag[TAG_W-1:0];

  // high bits of the max-width entry are unused in narrower configurations
  logic unused_bits;
  assign unused_bits = ^{main_q.imm, main_q.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench. Two instances share the inputs:
// d64 (XLEN=64, CNT_W=16) and d32 (XLEN=32, CNT_W=2 for saturation).
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;

  logic        rdy64, vld64, ill64, rdy32, vld32, ill32;
  logic [63:0] imm64;
  logic [31:0] imm32;
  logic [2:0]  fmt64, fmt32;
  logic [7:0]  tag64, tag32;
  logic [15:0] cnt64;
  logic [1:0]  cnt32;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) d64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64),
    .illegal_cnt(cnt64)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) d32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32),
    .illegal_cnt(cnt32)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [7:0] tag);
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic exp_out(input string name, input logic [63:0] i64, input logic [31:0] i32,
                         input logic [2:0] f, input logic il, input logic [7:0] tg);
    chk({name, ".valid"},   {63'b0, vld64}, 64'd1);
    chk({name, ".imm64"},   imm64, i64);
    chk({name, ".imm32"},   {32'b0, imm32}, {32'b0, i32});
    chk({name, ".fmt"},     {61'b0, fmt64}, {61'b0, f});
    chk({name, ".fmt32"},   {61'b0, fmt32}, {61'b0, f});
    chk({name, ".illegal"}, {63'b0, ill64}, {63'b0, il});
    chk({name, ".tag"},     {56'b0, tag64}, {56'b0, tg});
  endtask

  task automatic exp_reset(input string name);
    chk({name, ".valid64"}, {63'b0, vld64}, 64'd0);
    chk({name, ".valid32"}, {63'b0, vld32}, 64'd0);
    chk({name, ".ready64"}, {63'b0, rdy64}, 64'd1);
    chk({name, ".ready32"}, {63'b0, rdy32}, 64'd1);
    chk({name, ".imm64"},   imm64, 64'd0);
    chk({name, ".imm32"},   {32'b0, imm32}, 64'd0);
    chk({name, ".fmt"},     {61'b0, fmt64}, 64'd7);
    chk({name, ".illegal"}, {63'b0, ill64}, 64'd0);
    chk({name, ".tag"},     {56'b0, tag64}, 64'd0);
    chk({name, ".cnt64"},   {48'b0, cnt64}, 64'd0);
    chk({name, ".cnt32"},   {62'b0, cnt32}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_tag = '0;
    cyc(); cyc();
    exp_reset("reset");
    rst_n = 1'b1;

    // streaming decode, out_ready=1: each result appears after its accept edge
    send(32'hFFF00093, 8'h11); exp_out("addi",  64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0, 8'h11);
    send(32'hFE20AE23, 8'h12); exp_out("sw",    64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd1, 1'b0, 8'h12);
    send(32'h00000863, 8'h13); exp_out("beq",   64'h10, 32'h10, 3'd2, 1'b0, 8'h13);
    send(32'h800002B7, 8'h14); exp_out("lui",   64'hFFFFFFFF80000000, 32'h80000000, 3'd3, 1'b0, 8'h14);
    send(32'h008000EF, 8'h15); exp_out("jal",   64'h8, 32'h8, 3'd4, 1'b0, 8'h15);
    send(32'h43F0D093, 8'h16); exp_out("srai",  64'd63, 32'd31, 3'd5, 1'b0, 8'h16);
    send(32'h03F0909B, 8'h17); exp_out("slliw", 64'd31, 32'd31, 3'd5, 1'b0, 8'h17);
    send(32'h340FD073, 8'h18); exp_out("csrwi", 64'd31, 32'd31, 3'd6, 1'b0, 8'h18);
    send(32'h00000073, 8'h19); exp_out("ecall", 64'd0, 32'd0, 3'd7, 1'b0, 8'h19);
    send(32'h0000007F, 8'h1A); exp_out("illeg", 64'd0, 32'd0, 3'd7, 1'b1, 8'h1A);
    cyc();
    chk("drain.valid", {63'b0, vld64}, 64'd0);
    chk("cnt64.1", {48'b0, cnt64}, 64'd1);
    chk("cnt32.1", {62'b0, cnt32}, 64'd1);

    // three more illegals: 2-bit counter saturates at 3
    send(32'h0000007F, 8'h1B);
    send(32'h0000007F, 8'h1C);
    chk("cnt32.2", {62'b0, cnt32}, 64'd2);
    send(32'h0000007F, 8'h1D);
    cyc();
    chk("cnt64.4", {48'b0, cnt64}, 64'd4);
    chk("cnt32.sat", {62'b0, cnt32}, 64'd3);

    // backpressure: tags 1,2 fill the buffer, 3 waits, all emerge in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093;
    in_tag = 8'd1; cyc();
    chk("bp1.ready", {63'b0, rdy64}, 64'd1);
    chk("bp1.tag",   {56'b0, tag64}, 64'd1);
    in_tag = 8'd2; cyc();
    chk("bp2.ready", {63'b0, rdy64}, 64'd0);
    chk("bp2.tag",   {56'b0, tag64}, 64'd1);
    in_tag = 8'd3; cyc();
    chk("bp3.ready", {63'b0, rdy64}, 64'd0);
    chk("bp3.tag",   {56'b0, tag64}, 64'd1);
    chk("bp3.valid", {63'b0, vld64}, 64'd1);
    out_ready = 1'b1; cyc();
    chk("rel1.tag",   {56'b0, tag64}, 64'd2);
    chk("rel1.ready", {63'b0, rdy64}, 64'd1);
    cyc();
    chk("rel2.tag",   {56'b0, tag64}, 64'd3);
    chk("rel2.valid", {63'b0, vld64}, 64'd1);
    in_valid = 1'b0; cyc();
    chk("rel3.valid", {63'b0, vld64}, 64'd0);

    // flush while full, with a new instruction offered in the same cycle
    out_ready = 1'b0;
    send(32'hFFF00093, 8'd4);
    send(32'hFFF00093, 8'd5);
    chk("fl.ready_full", {63'b0, rdy64}, 64'd0);
    in_valid = 1'b1; in_tag = 8'd6; flush = 1'b1; cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl.valid", {63'b0, vld64}, 64'd0);
    chk("fl.ready", {63'b0, rdy64}, 64'd1);
    cyc();
    chk("fl.absent", {63'b0, vld64}, 64'd0);

    // reset mid-operation, then first accept straight after release
    send(32'h0000007F, 8'd7);
    chk("pre_rst.valid", {63'b0, vld64}, 64'd1);
    chk("pre_rst.tag",   {56'b0, tag64}, 64'd7);
    rst_n = 1'b0; #1;
    exp_reset("async_rst");
    cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    send(32'h800002B7, 8'd8);
    exp_out("post_rst", 64'hFFFFFFFF80000000, 32'h80000000, 3'd3, 1'b0, 8'd8);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount and CSR zimm) and sign- or zero-extends the result to XLEN. Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so the block can stall independently of fetch. It also flags and counts instructions whose opcode carries no defined format.

## Interface
Parameters:
- XLEN, 64, output immediate width; 32 or 64 only.
- TAG_W, 8, width of the sideband tag (PC index / ROB id) carried with each instruction.
- CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept; registered.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: I=0, S=1, B=2, U=3, J=4, SH=5, Z=6, NONE=7.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the result.
- illegal_cnt  out  CNT_W  saturating count of illegal results delivered.

## Operation
- Decode by opcode in_instr[6:0]:
  - I format: 0000011, 0010011, 0011011, 1100111.
  - S format: 0100011.
  - B format: 1100011.
  - U format: 0110111, 0010111.
  - J format: 1101111.
  - SYSTEM 1110011: funct3≠0 gives Z; funct3=0 gives NONE with imm 0, legal.
  - Any other opcode: NONE, imm 0, out_illegal=1.
- SH override: opcode 0010011 with funct3 001/101 gives shamt zero-extended. Shamt is instr[25:20] for XLEN=64, instr[24:20] for XLEN=32. Opcode 0011011 with funct3 001/101 always uses instr[24:20].
- Bit fields:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Z: instr[19:15].
- Extension: I, S, B, U and J are sign-extended from instr[31] to XLEN. SH and Z are zero-extended.
- Skid buffer has states EMPTY, ONE (main register full) and TWO (main + skid full):
  - EMPTY, accept → ONE.
  - ONE, accept without drain → TWO.
  - ONE, drain without accept → EMPTY.
  - ONE, accept and drain → ONE.
  - TWO, drain → ONE, with skid moving into main.
- in_ready = (state≠TWO), registered. Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Ordering is strictly FIFO.
- illegal_cnt increments on each drain with out_illegal=1 and saturates at all-ones.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Throughput is 1 per cycle while out_ready=1.
- out_* and out_valid are driven from the main register only; there is no combinational path from in_* to out_*.
- out_* must be held stable while out_valid=1 and out_ready=0.
- flush: the next state is EMPTY and in_ready=1, and any accept in the same cycle is discarded. illegal_cnt is not reset by flush, and a drain coinciding with flush still counts.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=7, out_illegal=0, out_tag=0, illegal_cnt=0.
- Reset asserted mid-operation empties the buffer immediately; in-flight entries are lost.
- The first accept after rst_n deasserts occurs at the first rising edge at which in_valid=1.

## Structure
- Package imm_gen_pkg holds:
  - opcode localparams;
  - the format enum (I, S, B, U, J, SH, Z, NONE) in 3 bits;
  - a packed struct {imm, fmt, illegal, tag} used for the main and skid registers.
- Sub-module imm_decode: purely combinational, parametrised by XLEN; maps instr to {imm, fmt, illegal}.
- The top level contains the skid FSM, data registers and counter.

## Test plan
- 0xFFF00093 (addi, -1), XLEN=64 → out_imm 0xFFFFFFFFFFFFFFFF, fmt I, next cycle.
- 0xFE20AE23 (sw, -4) → 0xFFFFFFFFFFFFFFFC, fmt S.
- 0x00000863 (beq, +16) → 0x10, fmt B.
- 0x800002B7 (lui) → 0xFFFFFFFF80000000 at XLEN=64, 0x80000000 at XLEN=32, fmt U.
- 0x43F0D093 (srai 63) at XLEN=64 → 63, fmt SH, not 0x43F.
- 0x0000007F → imm 0, fmt NONE, illegal=1; illegal_cnt increments to 1 on drain. Also check saturation with CNT_W=2.
- out_ready=0 with three back-to-back tags 1, 2, 3:
  - tags 1 and 2 are accepted, then in_ready=0;
  - after release, tags 1, 2, 3 emerge in order with no loss.
- Flush in TWO with in_valid=1 → next cycle out_valid=0 and in_ready=1; the new instruction is absent.
- rst_n pulsed low while in ONE → all outputs at reset values immediately.
